// File: rtl/lut_neuron_cfg.sv
// ---------------------------------------------------------------------------
// lut_neuron_cfg : runtime-writable LUT neuron with a valid/ready lookup stream
// Optional readback port enabled by defining LUT_CFG_READBACK_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lut_neuron_cfg #(
  parameter int                  FAN_IN     = 4,
  parameter int                  IN_BITS    = 2,
  parameter int                  OUT_BITS   = 2,
  parameter logic [OUT_BITS-1:0] INIT_VALUE = 2'b11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FAN_IN*IN_BITS-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_BITS-1:0]         out_data,
  input  logic                        cfg_we,
  output logic                        cfg_ready,
  input  logic [FAN_IN*IN_BITS-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0]         cfg_data,
  output logic                        busy
`ifdef LUT_CFG_READBACK_EN
  ,
  input  logic                        cfg_re,
  output logic                        cfg_rvalid,
  output logic [OUT_BITS-1:0]         cfg_rdata
`endif
);

  localparam int ADDR_W = FAN_IN * IN_BITS;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [ADDR_W:0] c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] c_cnt_last = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
  logic [OUT_BITS-1:0] table_q [DEPTH];
  logic                out_valid_q;
  logic [OUT_BITS-1:0] out_data_q;

  logic                w_run;
  logic                w_accept;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [OUT_BITS-1:0] w_wr_data;

  assign w_run     = (state_q == S_RUN);
  assign busy      = !w_run;
  assign cfg_ready = w_run;
  assign in_ready  = w_run && (!out_valid_q || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + c_cnt_one;
        if (clr_cnt_q == c_cnt_last) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
    endcase
  end

  // One shared write port: the clear sweep owns it until RUN, then the config port.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = clr_cnt_q[ADDR_W-1:0];
    w_wr_data = INIT_VALUE;
    if (!w_run) begin
      w_wr_en = 1'b1;
    end else if (cfg_we) begin
      w_wr_en   = 1'b1;
      w_wr_addr = cfg_addr;
      w_wr_data = cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      table_q[w_wr_addr] <= w_wr_data;
    end
  end

  // Reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (w_accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= table_q[in_data];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef LUT_CFG_READBACK_EN
  logic                rvalid_q;
  logic [OUT_BITS-1:0] rdata_q;
  logic                w_rd_req;

  assign w_rd_req   = w_run && cfg_re && !cfg_we;
  assign cfg_rvalid = rvalid_q;
  assign cfg_rdata  = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= w_rd_req;
      if (w_rd_req) begin
        rdata_q <= table_q[cfg_addr];
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lut_neuron_cfg.sv
// ---------------------------------------------------------------------------
// tb_lut_neuron_cfg : directed bench with a table-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lut_neuron_cfg;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, cfg_addr;
  logic [1:0] out_data, cfg_data;
  logic       cfg_we, cfg_ready, busy;
`ifdef LUT_CFG_READBACK_EN
  logic       cfg_re, cfg_rvalid;
  logic [1:0] cfg_rdata;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  lut_neuron_cfg dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .busy(busy)
`ifdef LUT_CFG_READBACK_EN
    , .cfg_re(cfg_re), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] pat(input logic [7:0] a);
    return a[1:0] ^ a[7:6];
  endfunction

  // Reference model: a plain table plus a one-deep output slot.
  logic [1:0] m_tbl [DEPTH];
  int         m_clear_left = DEPTH;
  logic       m_ov = 1'b0;
  logic [1:0] m_od = 2'b00;
  logic       m_acc;
  logic       m_rv = 1'b0;
  logic [1:0] m_rd = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_clear_left = DEPTH;
      m_ov = 1'b0;
      m_od = 2'b00;
      m_rv = 1'b0;
      m_rd = 2'b00;
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = 2'b11;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else begin
      m_acc = in_valid && (!m_ov || out_ready);
`ifdef LUT_CFG_READBACK_EN
      m_rv = cfg_re && !cfg_we;
      if (m_rv) m_rd = m_tbl[cfg_addr];
`endif
      if (m_acc) begin
        m_od = m_tbl[in_data];
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (cfg_we) m_tbl[cfg_addr] = cfg_data;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_clear_left != 0);
    check("cfg_ready", cfg_ready, m_clear_left == 0);
    check("in_ready", in_ready, (m_clear_left == 0) && (!m_ov || out_ready));
    check("out_valid", out_valid, m_ov);
    if (m_ov) check("out_data", out_data, m_od);
`ifdef LUT_CFG_READBACK_EN
    check("cfg_rvalid", cfg_rvalid, m_rv);
    if (m_rv) check("cfg_rdata", cfg_rdata, m_rd);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_sweep(input string name);
    int cnt = 0;
    int budget = 0;
    logic saw_ready = 1'b0;
    while (budget < 1000) begin
      @(negedge clk);
      budget++;
      if (!busy) break;
      cnt++;
      if (in_ready) saw_ready = 1'b1;
    end
    check(name, cnt, 256);
    check({name, "_in_ready"}, saw_ready, 1'b0);
  endtask

  task automatic lookup(input string name, input logic [7:0] addr, input logic [1:0] exp);
    tick();
    in_valid  = 1'b1;
    in_data   = addr;
    out_ready = 1'b1;
    tick();
    check(name, {out_valid, out_data}, {1'b1, exp});
    in_valid = 1'b0;
  endtask

  initial begin
    int gaps;
    int bad;
    in_valid = 0; in_data = 0; out_ready = 0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0;
`ifdef LUT_CFG_READBACK_EN
    cfg_re = 0;
`endif
    rst = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 2'b00);
    check("rst_busy", busy, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b0);

    rst = 1'b0;
    in_valid = 1'b1;
    count_sweep("sweep1_len");
    in_valid = 1'b0;
    lookup("init_00", 8'h00, 2'b11);
    lookup("init_5A", 8'h5A, 2'b11);
    lookup("init_FF", 8'hFF, 2'b11);

    for (int a = 0; a < DEPTH; a++) begin
      cfg_we = 1'b1; cfg_addr = 8'(a); cfg_data = pat(8'(a));
      tick();
    end
    cfg_we = 1'b0;

    gaps = 0; bad = 0;
    out_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      in_valid = 1'b1; in_data = 8'(a);
      tick();
      if (!out_valid) gaps++;
      if (out_data !== pat(8'(a))) bad++;
    end
    in_valid = 1'b0;
    check("stream_gaps", gaps, 0);
    check("stream_data_errors", bad, 0);

    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    tick();
    check("bp_first", {out_valid, out_data}, 3'b1_01);
    out_ready = 1'b0; in_data = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {out_valid, out_data}, 3'b1_01);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", {out_valid, out_data}, 3'b1_00);
    in_valid = 1'b0;
    tick();
    check("bp_drain", out_valid, 1'b0);

    cfg_we = 1'b1; cfg_addr = 8'h3C; cfg_data = 2'b10;
    tick();
    cfg_data = 2'b01; in_valid = 1'b1; in_data = 8'h3C;
    tick();
    check("coll_old", {out_valid, out_data}, 3'b1_10);
    cfg_we = 1'b0;
    tick();
    check("coll_new", {out_valid, out_data}, 3'b1_01);
    in_valid = 1'b0;

`ifdef LUT_CFG_READBACK_EN
    cfg_we = 1'b1; cfg_addr = 8'hA5; cfg_data = 2'b10;
    tick();
    cfg_we = 1'b0; cfg_re = 1'b1;
    tick();
    check("rb_read", {cfg_rvalid, cfg_rdata}, 3'b1_10);
    cfg_re = 1'b0;
    tick();
    check("rb_pulse", cfg_rvalid, 1'b0);
    cfg_re = 1'b1; cfg_we = 1'b1; cfg_data = 2'b01;
    tick();
    check("rb_wr_prio", cfg_rvalid, 1'b0);
    cfg_re = 1'b0; cfg_we = 1'b0;
`endif

    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("mid_async_drop", out_valid, 1'b0);
    check("mid_busy", busy, 1'b1);
    repeat (2) tick();
    rst = 1'b0;
    count_sweep("sweep2_len");
    lookup("post_rst_3C", 8'h3C, 2'b11);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/lut_neuron_cfg.md
Name: lut_neuron_cfg

Overview:
- Parametrised, pipelined successor to the generated fixed-ROM LUT neurons.
- Truth table has FAN_IN inputs of IN_BITS each and OUT_BITS outputs. It lives in distributed RAM, cleared after reset and rewritten at runtime through a config port, so new layer weights load without resynthesis.
- Lookups use a valid/ready stream with a registered output.
- Sits in layer wrappers as a drop-in neuron for in-field retraining and pipecleaner experiments.

Parameters:
- FAN_IN, 4, number of neuron inputs.
- IN_BITS, 2, bits per quantised input.
- OUT_BITS, 2, bits of quantised output.
- INIT_VALUE, 2'b11 (width OUT_BITS), table entry value written to every address during post-reset clear.
- ADDR_W, FAN_IN*IN_BITS (derived, not overridable), table address width; depth is 2^ADDR_W.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  block accepts a lookup this cycle.
- in_data  in  ADDR_W  concatenated quantised inputs; input k occupies bits [k*IN_BITS +: IN_BITS] and is used directly as the table address.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_BITS  looked-up activation.
- cfg_we  in  1  table write request.
- cfg_ready  out  1  table write accepted this cycle.
- cfg_addr  in  ADDR_W  table write address.
- cfg_data  in  OUT_BITS  table write value.
- busy  out  1  high while the clear sweep runs.

Behaviour:
Reset:
- Outputs reset to: in_ready=0, cfg_ready=0, out_valid=0, out_data=0, busy=1.
- Counter resets to 0 and the FSM to CLEAR.

FSM states:
- CLEAR: writes INIT_VALUE to address clr_cnt each cycle and increments clr_cnt.
  - On the cycle writing address 2^ADDR_W-1, moves to RUN.
  - The sweep takes exactly 2^ADDR_W cycles after rst deasserts; with defaults that is 256.
  - in_ready=0, cfg_ready=0 and busy=1 throughout.
- RUN: busy=0, cfg_ready=1, in_ready = !out_valid || out_ready.
- No other states. Only rst re-enters CLEAR.

Lookup:
- A transfer occurs when in_valid && in_ready. On the next edge out_data <= table[in_data] and out_valid <= 1, so latency is 1 cycle.
- out_data and out_valid hold while out_valid && !out_ready.
- out_valid clears when out_ready is high and no new transfer occurs.
- Full throughput is one lookup per cycle when out_ready stays high.

Config:
- A write occurs when cfg_we && cfg_ready. table[cfg_addr] <= cfg_data at the edge.
- A lookup and a write in the same cycle are both performed. The lookup reads the old value (read-before-write), including when cfg_addr == in_data.
- A lookup accepted on the cycle after the write sees the new value.
- cfg_we during CLEAR is ignored (not queued); the sender must wait for cfg_ready.

Reset mid-operation:
- Asynchronous reset at any time drops out_valid immediately and discards any pending output.
- Table contents are then cleared by a new sweep.

Width rules:
- No arithmetic on data; addresses are used unsigned.
- clr_cnt is ADDR_W+1 bits so termination is unambiguous at the maximum depth.

Optional Feature:
- Macro: LUT_CFG_READBACK_EN.
- When defined, adds the following ports:
  - cfg_re  in  1
  - cfg_rvalid  out  1
  - cfg_rdata  out  OUT_BITS
- Readback timing:
  - In RUN, cfg_re && !cfg_we reads table[cfg_addr]; cfg_rdata is registered and valid with cfg_rvalid=1 exactly one cycle later.
  - cfg_rvalid is high for one cycle only.
  - cfg_re together with cfg_we gives write priority: no readback, cfg_rvalid=0.
  - cfg_re during CLEAR is ignored.
  - cfg_rvalid and cfg_rdata reset to 0.
- When the macro is undefined these ports do not exist and no readback logic is built.

Test Plan:
- Clear sweep: release rst, hold in_valid=1. busy=1 and in_ready=0 for exactly 256 cycles, then busy=0. Lookups of 8'h00, 8'h5A and 8'hFF all return 2'b11.
- Load and stream: write table[a]=a[1:0]^a[7:6] for all 256 addresses, then stream all 256 addresses with out_ready=1. Expect 256 back-to-back results matching, with 1-cycle latency and no gaps.
- Backpressure: with out_valid=1, hold out_ready=0 for 5 cycles. out_data stays stable, in_ready=0 and no lookup is lost. On release, the next queued input's result follows after 1 cycle.
- Write/read collision: same cycle cfg_we, addr 8'h3C, data 2'b01, with lookup 8'h3C (old value 2'b10). out_data=2'b10. The following lookup of 8'h3C returns 2'b01.
- Mid-stream reset: pulse rst while out_valid=1. out_valid drops asynchronously, a new 256-cycle sweep runs, and the previously written 8'h3C now reads 2'b11.
- (LUT_CFG_READBACK_EN) Write 2'b10 to 8'hA5, then cfg_re at 8'hA5. Next cycle cfg_rvalid=1 and cfg_rdata=2'b10. cfg_re together with cfg_we gives cfg_rvalid=0.
